// File: rtl/reg_file_wb.sv
// Writeback stage register file: selects the WB result, commits it to storage and
// serves two combinational decode read ports with write-through bypass.
module reg_file_wb #(
    parameter int unsigned data_width = 32,
    parameter int unsigned op_width   = 5,
    parameter int unsigned cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_wr_w,
    input  logic                  mem2reg_w,
    input  logic [data_width-1:0] data_w,
    input  logic [data_width-1:0] alu_result_w,
    input  logic [op_width-1:0]   write_reg_w,
    input  logic [op_width-1:0]   rs_addr_d,
    input  logic [op_width-1:0]   rt_addr_d,
    output logic [data_width-1:0] rs_data_d,
    output logic [data_width-1:0] rt_data_d,
    output logic [data_width-1:0] result_w,
    output logic [cnt_width-1:0]  wr_count
);

    localparam int depth = 2 ** op_width;
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [data_width-1:0] regs [depth];
    logic [cnt_width-1:0]  wr_count_q;
    logic                  commit;

    assign result_w = mem2reg_w ? data_w : alu_result_w;
    assign commit   = reg_wr_w && (write_reg_w != '0);
    assign wr_count = wr_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                regs[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (commit) begin
                regs[write_reg_w] <= result_w;
                if (wr_count_q != '1) begin
                    wr_count_q <= wr_count_q + cnt_one;
                end
            end
        end
    end

    // r0 is forced to zero on read so a bypass match on address 0 can never leak through.
    always_comb begin
        rs_data_d = regs[rs_addr_d];
        if (rs_addr_d == '0) begin
            rs_data_d = '0;
        end else if (reg_wr_w && (write_reg_w == rs_addr_d)) begin
            rs_data_d = result_w;
        end
    end

    always_comb begin
        rt_data_d = regs[rt_addr_d];
        if (rt_addr_d == '0) begin
            rt_data_d = '0;
        end else if (reg_wr_w && (write_reg_w == rt_addr_d)) begin
            rt_data_d = result_w;
        end
    end

endmodule
